// File: rtl/intpol2_pkg.sv
// Shared definitions for the interpolator input-FIFO feeder.
// Holds default widths, the FIFO almost-full margin and the feeder FSM states.
package intpol2_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH     = 4;
  localparam int unsigned FIFO_AF_MARGIN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PUSH  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/intpol2_pace_counter.sv
// Loadable down-counter that times the idle gap between FIFO writes.
// The count stops at zero; zero is flagged combinationally.
module intpol2_pace_counter
  import intpol2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && !zero) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/intpol2_fifo_feeder.sv
// Streams n_samples words from the local sample memory into the interpolator
// input FIFO, honouring almost-full back-pressure and an optional pacing gap.
module intpol2_fifo_feeder
  import intpol2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = intpol2_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = intpol2_pkg::ADDR_WIDTH,
  parameter int unsigned RATE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_samples,
  input  logic [RATE_WIDTH-1:0] rate_div,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  afull_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  feeder_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH:0]   idx_nxt;
  logic [RATE_WIDTH-1:0] rate_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pace_load;
  logic                  pace_en;
  logic                  pace_zero;

  assign idx_nxt = idx_q + 1'b1;
  assign data_o  = data_q;

  // Loaded with rate-1 so that WAIT lasts exactly rate cycles.
  intpol2_pace_counter #(
    .WIDTH(RATE_WIDTH)
  ) u_pace (
    .clk      (clk),
    .rstn     (rstn),
    .load     (pace_load),
    .en       (pace_en),
    .load_val (rate_q - 1'b1),
    .zero     (pace_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      rate_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        len_q  <= (n_samples > MAX_LEN) ? MAX_LEN : n_samples;
        rate_q <= rate_div;
        idx_q  <= '0;
      end
      if (state_q == FETCH) begin
        data_q <= rd_data_i;
      end
      if (wr_en_o) begin
        idx_q <= idx_nxt;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    busy_o    = 1'b0;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    pace_load = 1'b0;
    pace_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (n_samples == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        busy_o    = 1'b1;
        rd_addr_o = idx_q[ADDR_WIDTH-1:0];
        state_d   = PUSH;
      end
      PUSH: begin
        busy_o = 1'b1;
        if (afull_i) begin
          stall_o = 1'b1;
        end else begin
          wr_en_o = 1'b1;
          if (idx_nxt == len_q) begin
            state_d = DONE;
          end else if (rate_q != '0) begin
            pace_load = 1'b1;
            state_d   = WAIT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WAIT: begin
        busy_o  = 1'b1;
        pace_en = 1'b1;
        if (pace_zero) begin
          state_d = FETCH;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
